// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - mul/div sequencing and load-use stall control
// Holds the front of the pipeline while multdiv runs, and bubbles DX on a load-use hazard.
module pipeline_stall_controller #(
  parameter int TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] inFD,
  input  logic [31:0] inDX,
  input  logic        mdReady,
  input  logic        mdException,
  output logic        stallFD,
  output logic        stallDX,
  output logic        nopDX,
  output logic        nopXM,
  output logic        ctrlMULT,
  output logic        ctrlDIV,
  output logic        mdBusy,
  output logic        mdTimeout,
  output logic        mdErr,
  output logic [5:0]  mdCount
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;
  localparam logic [5:0] COUNT_LIMIT = 6'(TIMEOUT - 1);

  state_t state, nextState;

  logic [4:0] fdOp, fdRd, fdRs, fdRt, dxOp, dxRd;
  logic       dxMul, dxDiv, dxStart;
  logic       fdUsesRs, fdUsesRt, fdUsesRd, loadUse, timeoutHit;
  logic       unusedBits;

  assign fdOp = inFD[31:27];
  assign fdRd = inFD[26:22];
  assign fdRs = inFD[21:17];
  assign fdRt = inFD[16:12];
  assign dxOp = inDX[31:27];
  assign dxRd = inDX[26:22];
  assign unusedBits = ^{inFD[11:0], inDX[21:7], inDX[1:0]};

  assign dxMul   = (dxOp == OP_RTYPE) && (inDX[6:2] == ALU_MUL);
  assign dxDiv   = (dxOp == OP_RTYPE) && (inDX[6:2] == ALU_DIV);
  assign dxStart = dxMul || dxDiv;

  // Store and branch formats carry a source register in the rd slot.
  assign fdUsesRs = !((fdOp == OP_J) || (fdOp == OP_JAL) || (fdOp == OP_SETX));
  assign fdUsesRt = (fdOp == OP_RTYPE);
  assign fdUsesRd = (fdOp == OP_SW) || (fdOp == OP_BNE) || (fdOp == OP_BLT) || (fdOp == OP_JR);

  assign loadUse = (dxOp == OP_LW) && (dxRd != 5'd0) &&
                   ((fdUsesRs && (fdRs == dxRd)) ||
                    (fdUsesRt && (fdRt == dxRd)) ||
                    (fdUsesRd && (fdRd == dxRd)));

  assign timeoutHit = (state == BUSY) && !mdReady && (mdCount == COUNT_LIMIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (dxStart) nextState = BUSY;
      BUSY:    if (mdReady || timeoutHit) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mdCount <= 6'd0;
      mdErr   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (dxStart) mdCount <= 6'd0;
        BUSY: begin
          if (mdCount != 6'd63) mdCount <= mdCount + 6'd1;
          if (mdReady)         mdErr <= mdException;
          else if (timeoutHit) mdErr <= 1'b1;
        end
        DONE:    mdErr <= 1'b0;
        default: ;
      endcase
    end
  end

  // Gated by reset so every output drops the moment reset asserts.
  always_comb begin
    stallFD   = 1'b0;
    stallDX   = 1'b0;
    nopDX     = 1'b0;
    nopXM     = 1'b0;
    ctrlMULT  = 1'b0;
    ctrlDIV   = 1'b0;
    mdBusy    = 1'b0;
    mdTimeout = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (dxStart) begin
            ctrlMULT = dxMul;
            ctrlDIV  = dxDiv;
            stallFD  = 1'b1;
            stallDX  = 1'b1;
            nopXM    = 1'b1;
          end else if (loadUse) begin
            stallFD = 1'b1;
            nopDX   = 1'b1;
          end
        end
        BUSY: begin
          stallFD   = 1'b1;
          stallDX   = 1'b1;
          nopXM     = 1'b1;
          mdBusy    = 1'b1;
          mdTimeout = timeoutHit;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - scoreboard bench for pipeline_stall_controller
// Driver runs a small pipeline plus reference model; monitor compares every cycle.
module tb_pipeline_stall_controller;

  localparam int TIMEOUT = 40;
  localparam int NCYC    = 2500;

  logic        clock, reset;
  logic [31:0] inFD, inDX;
  logic        mdReady, mdException;
  logic        stallFD, stallDX, nopDX, nopXM, ctrlMULT, ctrlDIV, mdBusy, mdTimeout, mdErr;
  logic [5:0]  mdCount;

  pipeline_stall_controller #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .inFD(inFD), .inDX(inDX),
    .mdReady(mdReady), .mdException(mdException),
    .stallFD(stallFD), .stallDX(stallDX), .nopDX(nopDX), .nopXM(nopXM),
    .ctrlMULT(ctrlMULT), .ctrlDIV(ctrlDIV), .mdBusy(mdBusy),
    .mdTimeout(mdTimeout), .mdErr(mdErr), .mdCount(mdCount)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  logic [14:0] expQ[$];
  logic [31:0] prog[$];
  int          latQ[$];
  bit          excQ[$];
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] mkR(int rd, int rs, int rt, int alu);
    return {5'd0, 5'(rd), 5'(rs), 5'(rt), 5'd0, 5'(alu), 2'd0};
  endfunction

  function automatic logic [31:0] mkI(int op, int rd, int rs);
    return {5'(op), 5'(rd), 5'(rs), 17'(($urandom % 64))};
  endfunction

  function automatic bit isMulDiv(logic [31:0] i);
    return (i[31:27] == 5'd0) && ((i[6:2] == 5'd6) || (i[6:2] == 5'd7));
  endfunction

  function automatic bit hazard(logic [31:0] fd, logic [31:0] dx);
    int op, r;
    bit hit;
    op = int'(fd[31:27]);
    r  = int'(dx[26:22]);
    hit = 0;
    if (dx[31:27] != 5'd8 || r == 0) return 0;
    if (!(op == 1 || op == 3 || op == 21) && int'(fd[21:17]) == r) hit = 1;
    if (op == 0 && int'(fd[16:12]) == r) hit = 1;
    if ((op == 7 || op == 2 || op == 6 || op == 4) && int'(fd[26:22]) == r) hit = 1;
    return hit;
  endfunction

  function automatic logic [31:0] randInstr();
    int k;
    k = $urandom % 10;
    case (k)
      0:       return mkR($urandom % 4, $urandom % 4, $urandom % 4, 6);
      1:       return mkR($urandom % 4, $urandom % 4, $urandom % 4, 7);
      2, 3:    return mkI(8, $urandom % 4, $urandom % 4);
      4:       return mkR($urandom % 4, $urandom % 4, $urandom % 4, 0);
      5:       return mkI(7, $urandom % 4, $urandom % 4);
      6:       return mkI(2, $urandom % 4, $urandom % 4);
      7:       return mkI(4, $urandom % 4, $urandom % 4);
      8:       return mkI(1, $urandom % 4, $urandom % 4);
      default: return mkI(($urandom % 2) ? 3 : 21, $urandom % 4, $urandom % 4);
    endcase
  endfunction

  function automatic logic [31:0] nextInstr();
    if (prog.size() > 0) return prog.pop_front();
    return randInstr();
  endfunction

  // Model state: busyFor = BUSY cycles already elapsed (-1 when no op outstanding).
  int          busyFor, curLat, opsStarted, cntHeld;
  bit          inDone, errHeld, curExc, didReset;
  logic [31:0] fd, dx;

  initial begin
    logic sFD, sDX, nDX, nXM, cM, cD, bsy, tmo, eOut, rstVal;
    logic [5:0] cOut;
    bit adv, bubble;

    prog.push_back(mkR(3, 1, 2, 6));
    prog.push_back(mkR(4, 1, 2, 7));
    prog.push_back(mkR(1, 2, 3, 0));
    prog.push_back(mkI(8, 5, 1));
    prog.push_back(mkR(6, 5, 7, 0));
    prog.push_back(mkI(8, 0, 1));
    prog.push_back(mkR(6, 0, 7, 0));
    prog.push_back(mkR(2, 1, 3, 7));
    prog.push_back(mkR(3, 2, 1, 6));
    latQ.push_back(33); excQ.push_back(0);
    latQ.push_back(99); excQ.push_back(0);
    latQ.push_back(5);  excQ.push_back(1);
    latQ.push_back(20); excQ.push_back(0);
    latQ.push_back(7);  excQ.push_back(0);

    busyFor = -1; inDone = 0; cntHeld = 0; errHeld = 0;
    opsStarted = 0; didReset = 0; curLat = 0; curExc = 0;
    reset = 1'b0; inFD = '0; inDX = '0; mdReady = 0; mdException = 0;
    fd = nextInstr();
    dx = '0;

    @(posedge clock); #1;
    for (int c = 0; c < NCYC; c++) begin
      rstVal = (c >= 2);
      if (opsStarted == 4 && busyFor == 9 && !didReset) begin
        rstVal = 1'b0;
        didReset = 1;
      end
      if (busyFor >= 0) begin
        mdReady = (busyFor + 1 == curLat);
        mdException = curExc;
      end else begin
        mdReady = ($urandom % 4 == 0);
        mdException = $urandom % 2;
      end
      inFD = fd; inDX = dx; reset = rstVal;

      {sFD, sDX, nDX, nXM, cM, cD, bsy, tmo, eOut} = '0;
      cOut = 6'(cntHeld);
      adv = 0; bubble = 0;
      if (!rstVal) begin
        cOut = 6'd0;
        busyFor = -1; inDone = 0; cntHeld = 0; errHeld = 0;
      end else if (inDone) begin
        eOut = errHeld;
        inDone = 0; errHeld = 0;
        adv = 1;
      end else if (busyFor >= 0) begin
        {sFD, sDX, nXM, bsy} = 4'b1111;
        cOut = 6'(busyFor);
        if (mdReady) begin
          inDone = 1; errHeld = mdException; cntHeld = busyFor + 1; busyFor = -1;
        end else if (busyFor + 1 == TIMEOUT) begin
          tmo = 1; inDone = 1; errHeld = 1; cntHeld = busyFor + 1; busyFor = -1;
        end else begin
          busyFor++;
        end
      end else if (isMulDiv(dx)) begin
        cM = (dx[6:2] == 5'd6);
        cD = (dx[6:2] == 5'd7);
        {sFD, sDX, nXM} = 3'b111;
        busyFor = 0;
        opsStarted++;
        curLat = (latQ.size() > 0) ? latQ.pop_front() : $urandom_range(1, 50);
        curExc = (excQ.size() > 0) ? excQ.pop_front() : bit'($urandom % 2);
      end else if (hazard(fd, dx)) begin
        sFD = 1; nDX = 1; bubble = 1;
      end else begin
        adv = 1;
      end
      expQ.push_back({sFD, sDX, nDX, nXM, cM, cD, bsy, tmo, eOut, cOut});

      if (bubble) dx = '0;
      else if (adv) begin
        dx = fd;
        fd = nextInstr();
      end
      @(posedge clock); #1;
    end

    @(negedge clock); #1;
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [14:0] e, a;
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clock);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        a = {stallFD, stallDX, nopDX, nopXM, ctrlMULT, ctrlDIV, mdBusy, mdTimeout, mdErr, mdCount};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: got %b expected %b (sFD sDX nDX nXM cM cD bsy tmo err cnt)",
                   cyc, a, e);
        end
        cyc++;
      end
    end
  end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 Parameter TIMEOUT, default 40, meaning max BUSY cycles to wait for mdReady before forced completion (range 2..63).
REQ-002 clock  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 inFD  in  32  instruction in FD latch; opcode [31:27], rd [26:22], rs [21:17], rt [16:12].
REQ-005 inDX  in  32  instruction in DX latch; same fields, ALU op [6:2].
REQ-006 mdReady  in  1  multdiv result valid.
REQ-007 mdException  in  1  multdiv error, sampled with mdReady.
REQ-008 stallFD  out  1  hold PC and FD latch this cycle.
REQ-009 stallDX  out  1  hold DX latch this cycle.
REQ-010 nopDX  out  1  load all-zero instruction into DX at next edge.
REQ-011 nopXM  out  1  load all-zero instruction into XM at next edge.
REQ-012 ctrlMULT, ctrlDIV  out  1 each  one-cycle start pulses to multdiv.
REQ-013 mdBusy  out  1  FSM in BUSY.
REQ-014 mdTimeout  out  1  one-cycle pulse on forced completion.
REQ-015 mdErr  out  1  registered mdException, held through DONE.
REQ-016 mdCount  out  6  BUSY cycle count.

Function
REQ-017 Decode: lw = opcode 01000; R-type = 00000; mul = R-type & ALU op 00110; div = R-type & ALU op 00111; sw 00111, bne 00010, blt 00110, jr 00100 read field [26:22]; j 00001, jal 00011, setx 10101 read no register.
REQ-018 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-019 IDLE, DX mul: ctrlMULT=1, stallFD=stallDX=nopXM=1 same cycle; next state BUSY.
REQ-020 IDLE, DX div: ctrlDIV=1, same stalls; next state BUSY.
REQ-021 BUSY: stallFD=stallDX=nopXM=1, ctrl pulses 0, mdBusy=1, mdCount increments each cycle, saturating at 63.
REQ-022 BUSY & mdReady: next state DONE, mdErr<=mdException.
REQ-023 BUSY & !mdReady & mdCount==TIMEOUT-1: next state DONE, mdTimeout=1 that cycle, mdErr<=1.
REQ-024 DONE: all stalls 0 (DX advances into XM); next state IDLE; mdErr cleared on leaving DONE.
REQ-025 mdReady in IDLE, DONE or start cycle: ignored.
REQ-026 mdCount cleared to 0 on start cycle; holds value in DONE and IDLE.
REQ-027 Load-use (IDLE only, no mul/div in DX): DX lw with rd!=0 and FD reads rd (rs for all except j/jal/setx; rt for R-type; [26:22] for sw/bne/blt/jr) -> stallFD=1, nopDX=1, stallDX=0 for exactly that cycle.
REQ-028 Load-use with rd=0: no stall.
REQ-029 Back-to-back mul/div: the instruction entering DX after DONE starts a new sequence from IDLE without an extra idle cycle.
REQ-030 Outputs in IDLE with no hazard: all 0.

Reset
REQ-031 reset low: state IDLE, mdCount=0, mdErr=0, all outputs 0 immediately, independent of clock.
REQ-032 Reset asserted mid-BUSY: sequence abandoned; after release, a mul/div still in DX starts again from IDLE.

Verification
REQ-033 inDX=mul r3,r1,r2; mdReady high 33 cycles after ctrlMULT -> ctrlMULT one cycle, stallFD/stallDX/nopXM high 34 cycles, DONE one cycle with stalls 0, mdCount=33.
REQ-034 inDX=lw r5; inFD=add r6,r5,r7 -> stallFD=1, nopDX=1, stallDX=0 one cycle; with lw r0 -> no stall.
REQ-035 inDX=div, mdReady never asserted, TIMEOUT=40 -> mdTimeout pulse at BUSY cycle 40, mdErr=1 in DONE, then IDLE.
REQ-036 div with mdReady and mdException=1 -> mdErr=1 during DONE only, mdTimeout=0.
REQ-037 reset low at BUSY cycle 10 -> all outputs 0 asynchronously, mdCount=0; release with mul still in DX -> new ctrlMULT pulse next edge.
REQ-038 mul followed directly by div -> DONE then immediate ctrlDIV pulse in following cycle.
